// File: rtl/uart_rx_oversample_if.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample_if
//   Signal bundle between the 16x-oversampling UART receiver and its
//   surroundings (baud tick generator, serial pin, RX FIFO write port).
//
//   Handshake: rx_done is a valid-only strobe. It is high for exactly one
//   clk when rx_data has just been updated. There is no ready and no
//   backpressure, so the consumer must take rx_data in that cycle or later.
//   rx_data is held until the next good frame.
//
//   Signals
//     b_tick     1-clk pulse at BAUD_RATE*16
//     rx         serial line, idles high, asynchronous to clk
//     rx_data    last correctly framed byte
//     rx_done    1-clk strobe: rx_data just updated
//     rx_busy    receiver FSM is not idle
//     frame_err  1-clk strobe: stop bit sampled low
//     state_dbg  current FSM state encoding (0=IDLE 1=START 2=DATA 3=STOP)
//
//   Modports
//     master  side that drives b_tick/rx and observes the results
//     slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_oversample_if #(
    parameter int DATA_BITS = 8
);
    logic                 b_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_err;
    logic [1:0]           state_dbg;

    modport master (
        output b_tick, rx,
        input  rx_data, rx_done, rx_busy, frame_err, state_dbg
    );

    modport slave (
        input  b_tick, rx,
        output rx_data, rx_done, rx_busy, frame_err, state_dbg
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample
//   UART receiver, 8N1 style frame (start, DATA_BITS data LSB first, one
//   stop). Samples the serial line using a 16x oversampled baud tick: the
//   start bit is confirmed at its middle (tick 7), after which every
//   OVERSAMPLE ticks lands in the middle of the next bit.
//
//   Ports
//     clk   system clock
//     rst   asynchronous reset, active-high
//     bus   uart_rx_oversample_if.slave (b_tick, rx in; rx_data, rx_done,
//           rx_busy, frame_err, state_dbg out)
// ---------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_oversample_if.slave  bus
);
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Sampling points within a bit period of OVERSAMPLE ticks.
    localparam logic [3:0]     TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [3:0]           tick_cnt, tick_cnt_n;
    logic [BCW-1:0]       bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
    logic                 rx_done_q, rx_done_n;
    logic                 frame_err_q, frame_err_n;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    logic rx_meta, rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            rx_data_q   <= rx_data_n;
            rx_done_q   <= rx_done_n;
            frame_err_q <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        rx_data_n   = rx_data_q;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            IDLE: begin
                // Falling edge is looked for every clk, not only on ticks,
                // so start detection is at most one tick late.
                if (!rx_s) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end

            START: begin
                if (bus.b_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        if (!rx_s) begin
                            state_n    = DATA;
                            tick_cnt_n = '0;
                            bit_cnt_n  = '0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state_n    = IDLE;
                            tick_cnt_n = '0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (bus.b_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        shreg_n    = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_cnt_n = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught.
                if (bus.b_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        if (rx_s) begin
                            rx_data_n = shreg;
                            rx_done_n = 1'b1;
                        end else begin
                            frame_err_n = 1'b1;
                        end
                        state_n    = IDLE;
                        tick_cnt_n = '0;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state != IDLE);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversample
//   Directed bench for uart_rx_oversample. b_tick fires every TICK_DIV clks,
//   so one bit period is 16*TICK_DIV clks (scaled down from 9600 baud to
//   keep the run short).
// ---------------------------------------------------------------------------
module tb_uart_rx_oversample;
    localparam int TICK_DIV = 4;
    localparam int BIT      = 16 * TICK_DIV;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_oversample_if #(.DATA_BITS(8)) bus ();

    uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running tick generator, driven away from the active edge.
    int tick_div = 0;
    initial bus.b_tick = 1'b0;
    always @(negedge clk) begin
        tick_div   = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
        bus.b_tick = (tick_div == 0);
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         done_cyc  = 0;
    int         last_start = 0;
    logic       busy_seen = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_busy) busy_seen = 1'b1;
        if (bus.rx_done || bus.frame_err)
            check("done_ferr_exclusive", {31'd0, bus.rx_done & bus.frame_err}, 32'd0);
        if (bus.rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_single_clk", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0)
                check("unexpected_rx_done", 32'd1, 32'd0);
            else
                check("rx_data_scoreboard", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (bus.frame_err) begin
            ferr_cnt++;
            check("ferr_single_clk", {31'd0, prev_ferr}, 32'd0);
        end
        prev_done = bus.rx_done;
        prev_ferr = bus.frame_err;
    end

    // ---------------- driver tasks ----------------
    // Caller is always positioned just after a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
        bus.rx     = 1'b0;
        last_start = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        bus.rx = stop_val;
        repeat (stop_len) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic idle_clks(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int base_done;
    int base_ferr;
    int lat;

    initial begin
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. reset values and quiet idle line
        check("reset_rx_data",   {24'd0, bus.rx_data}, 32'h00);
        check("reset_rx_done",   {31'd0, bus.rx_done}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("reset_rx_busy",   {31'd0, bus.rx_busy}, 32'd0);
        check("reset_state",     {30'd0, bus.state_dbg}, 32'd0);
        idle_clks(2000);
        check("idle_done_cnt",   done_cnt, 0);
        check("idle_ferr_cnt",   ferr_cnt, 0);
        check("idle_busy_seen",  {31'd0, busy_seen}, 32'd0);
        check("idle_rx_data",    {24'd0, bus.rx_data}, 32'h00);

        // 2. single good byte 0x55, with latency window around 9.5 bits
        base_done = done_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, BIT);
        idle_clks(2 * BIT);
        check("b55_done_cnt", done_cnt - base_done, 1);
        check("b55_rx_data",  {24'd0, bus.rx_data}, 32'h55);
        check("b55_ferr_cnt", ferr_cnt, 0);
        lat = done_cyc - last_start;
        check("b55_latency_window",
              {31'd0, (lat >= (19 * BIT) / 2) && (lat <= (19 * BIT) / 2 + 2 + 2 * TICK_DIV + 4)},
              32'd1);

        // 3. back-to-back 0xA5, 0x3C with no idle gap
        base_done = done_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_frame(8'hA5, 1'b1, BIT);
        send_frame(8'h3C, 1'b1, BIT);
        idle_clks(2 * BIT);
        check("b2b_done_cnt", done_cnt - base_done, 2);
        check("b2b_rx_data",  {24'd0, bus.rx_data}, 32'h3C);
        check("b2b_queue_empty", exp_q.size(), 0);

        // 4. 3-tick glitch on rx: busy pulses, no outputs
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        busy_seen = 1'b0;
        bus.rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        idle_clks(2 * BIT);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_now",  {31'd0, bus.rx_busy}, 32'd0);
        check("glitch_done_cnt",  done_cnt - base_done, 0);
        check("glitch_ferr_cnt",  ferr_cnt - base_ferr, 0);
        check("glitch_rx_data",   {24'd0, bus.rx_data}, 32'h3C);

        // 5. good 0x12, then 0xFF with a low stop bit. The low stop is cut
        //    short after mid-stop so the trailing low is rejected as a glitch.
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, BIT);
        idle_clks(BIT);
        send_frame(8'hFF, 1'b0, (3 * BIT) / 4);
        idle_clks(3 * BIT);
        check("ferr_done_cnt", done_cnt - base_done, 1);
        check("ferr_ferr_cnt", ferr_cnt - base_ferr, 1);
        check("ferr_rx_data",  {24'd0, bus.rx_data}, 32'h12);

        // 6. reset during data bit 4, then a clean 0x81
        bus.rx = 1'b0;                       // start bit
        repeat (BIT) @(negedge clk);
        repeat (4 * BIT) @(negedge clk);     // data bits 0..3 of 0xF0
        bus.rx = 1'b1;                       // data bit 4
        repeat (BIT / 2) @(negedge clk);
        check("midframe_busy", {31'd0, bus.rx_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'h00);
        check("rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
        check("rst_state",   {30'd0, bus.state_dbg}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base_done = done_cnt;
        idle_clks(2 * BIT);
        check("post_rst_no_done", done_cnt - base_done, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, BIT);
        idle_clks(2 * BIT);
        check("post_rst_done_cnt", done_cnt - base_done, 1);
        check("post_rst_rx_data",  {24'd0, bus.rx_data}, 32'h81);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
